i2c_master_arbiter: RTL

Round-robin arbiter and transaction sequencer that shares the single I2C master inside `I2C_top` among `NUM_REQ` on-chip requesters. It latches one requester's transaction (address, direction, length, write payload) and launches it with a one-cycle `en` pulse. It then tracks the master's `busy` to completion and returns read data and `ack_error` status to the winning requester with a `done` pulse. It sits directly in front of the master's `en/read_write/no_of_bytes/data_in/slave_addr` inputs.

---
 rtl/i2c_master_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/i2c_master_arbiter.sv
// rtl/i2c_master_arbiter.sv - round-robin arbiter and transaction sequencer in front of a shared I2C master
module i2c_master_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BYTES = 10,
    parameter int START_TO  = 16,
    parameter int XFER_TO   = 4096
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ-1:0]             req_rw_i,
    input  logic [NUM_REQ*7-1:0]           req_addr_i,
    input  logic [NUM_REQ*10-1:0]          req_len_i,
    input  logic [NUM_REQ*MAX_BYTES*8-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]             gnt_o,
    output logic                           done_o,
    output logic                           err_o,
    output logic [1:0]                     err_code_o,
    output logic [MAX_BYTES*8-1:0]         rdata_o,
    output logic                           m_en_o,
    output logic                           m_read_write_o,
    output logic [6:0]                     m_slave_addr_o,
    output logic [9:0]                     m_no_of_bytes_o,
    output logic [MAX_BYTES*8-1:0]         m_data_in_o,
    input  logic [MAX_BYTES*8-1:0]         m_data_out_i,
    input  logic                           m_busy_i,
    input  logic                           m_ack_error_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_COMPLETE
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [12:0]            timer_q, timer_d;
    logic [1:0]             code_q, code_d;
    logic [MAX_BYTES*8-1:0] rdata_q, rdata_d;
    logic [MAX_BYTES*8-1:0] data_in_q, data_in_d;
    logic                   rw_q, rw_d;
    logic [6:0]             addr_q, addr_d;
    logic [9:0]             len_q, len_d;

    logic                   found;
    logic [IDX_W-1:0]       winner;
    logic [9:0]             sel_len;
    logic                   len_ok;

    function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
        return IDX_W'((base + off) % NUM_REQ);
    endfunction

    // Pick the first pending requester at or after rr_ptr, wrapping around
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr_q;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[wrap_idx(int'(rr_ptr_q), i)]) begin
                found  = 1'b1;
                winner = wrap_idx(int'(rr_ptr_q), i);
            end
        end
        sel_len = req_len_i[winner*10 +: 10];
        len_ok  = (sel_len != 10'd0) && (sel_len <= 10'(MAX_BYTES));
    end

    // State register and all latched transaction fields
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            timer_q   <= '0;
            code_q    <= '0;
            rdata_q   <= '0;
            data_in_q <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            timer_q   <= timer_d;
            code_q    <= code_d;
            rdata_q   <= rdata_d;
            data_in_q <= data_in_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
        end
    end

    // Next state: selection, launch, busy tracking with timeouts, result capture
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        code_d    = code_q;
        rdata_d   = rdata_q;
        data_in_d = data_in_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        len_d     = len_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d   = winner;
                    rr_ptr_d  = wrap_idx(int'(winner), 1);
                    rw_d      = req_rw_i[winner];
                    addr_d    = req_addr_i[winner*7 +: 7];
                    len_d     = sel_len;
                    data_in_d = req_wdata_i[winner*MAX_BYTES*8 +: MAX_BYTES*8];
                    if (len_ok) begin
                        state_d = S_LAUNCH;
                        code_d  = 2'd0;
                    end else begin
                        // Bad length never reaches the master
                        state_d = S_COMPLETE;
                        code_d  = 2'd3;
                    end
                end
            end
            S_LAUNCH: state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (m_busy_i) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q >= 13'(START_TO - 1)) begin
                    state_d = S_COMPLETE;
                    code_d  = 2'd2;
                end
            end
            S_WAIT_DONE: begin
                if (!m_busy_i) begin
                    if (rw_q) rdata_d = m_data_out_i;
                    code_d  = m_ack_error_i ? 2'd1 : 2'd0;
                    state_d = S_COMPLETE;
                end else if (timer_q >= 13'(XFER_TO - 1)) begin
                    state_d = S_COMPLETE;
                    code_d  = 2'd2;
                end
            end
            S_COMPLETE: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        // Timer restarts on every state change and saturates otherwise
        if (state_d != state_q) timer_d = '0;
        else if (timer_q == '1) timer_d = timer_q;
        else                    timer_d = timer_q + 13'd1;
    end

    // Moore outputs decoded from the current state
    always_comb begin
        gnt_o      = '0;
        m_en_o     = 1'b0;
        done_o     = 1'b0;
        err_o      = 1'b0;
        err_code_o = 2'd0;
        if (state_q != S_IDLE) gnt_o[owner_q] = 1'b1;
        if (state_q == S_LAUNCH) m_en_o = 1'b1;
        if (state_q == S_COMPLETE) begin
            done_o     = 1'b1;
            err_code_o = code_q;
            err_o      = (code_q != 2'd0);
        end
    end

    assign rdata_o         = rdata_q;
    assign m_read_write_o  = rw_q;
    assign m_slave_addr_o  = addr_q;
    assign m_no_of_bytes_o = len_q;
    assign m_data_in_o     = data_in_q;

endmodule
